// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone arbiter, grant held for a whole cyc tenure,
// watchdog aborts stalled strobes with err.
// Ports:
//   clk_i / rst_i: clock and async active-high reset.
//   m_*: per-master Wishbone inputs and the ack/err/data return path.
//   s_*: shared slave side.
//   grant_o: one-hot owner, all zero when idle.
module wb_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS-1:0][31:0]      m_adr_i,
  input  logic [NUM_MASTERS-1:0][31:0]      m_dat_i,
  input  logic [NUM_MASTERS-1:0][3:0]       m_sel_i,
  output logic [31:0]                       m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [31:0]                       s_adr_o,
  output logic [31:0]                       s_dat_o,
  output logic [3:0]                        s_sel_o,
  input  logic [31:0]                       s_dat_i,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  output logic [NUM_MASTERS-1:0]            grant_o
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int WW = (TW > 16) ? TW : 16;
  localparam logic [WW-1:0] TO_V = WW'(TIMEOUT);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);
  localparam bit WD_ON = (TIMEOUT != 0);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]          last_idx_q, last_idx_d;
  logic [WW-1:0]          wd_cnt_q, wd_cnt_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;

  logic          owned;
  logic          cyc_g;
  logic          stb_g;
  logic          timeout;
  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand_idx;
  int            cand;

  assign owned = (state_q == OWNED);
  assign cyc_g = owned & m_cyc_i[gnt_idx_q];
  // A strobe without cyc is not a bus request, so it is gated here.
  assign stb_g = cyc_g & m_stb_i[gnt_idx_q];
  // A slave response in the boundary cycle wins over the watchdog.
  assign timeout = WD_ON & stb_g & (wd_cnt_q == TO_V)
                 & ~s_ack_i & ~s_err_i;

  // Round-robin: first requester after the previous owner, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand     = (int'(last_idx_q) + i) % NUM_MASTERS;
      cand_idx = IW'(cand);
      if (!pick_vld && m_cyc_i[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  assign s_cyc_o = cyc_g;
  assign s_stb_o = stb_g;
  assign s_we_o  = owned & m_we_i[gnt_idx_q];
  assign s_adr_o = owned ? m_adr_i[gnt_idx_q] : '0;
  assign s_dat_o = owned ? m_dat_i[gnt_idx_q] : '0;
  assign s_sel_o = owned ? m_sel_i[gnt_idx_q] : '0;
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;

  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    if (owned) begin
      m_ack_o[gnt_idx_q] = s_ack_i;
      m_err_o[gnt_idx_q] = s_err_i | timeout;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_idx_d = last_idx_q;
    wd_cnt_d   = wd_cnt_q;
    grant_d    = grant_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d   = OWNED;
          gnt_idx_d = pick_idx;
          wd_cnt_d  = '0;
          grant_d   = ONE << pick_idx;
        end
      end
      OWNED: begin
        if (WD_ON && stb_g && !s_ack_i && !s_err_i && !timeout) begin
          wd_cnt_d = wd_cnt_q + WW'(1);
        end else begin
          wd_cnt_d = '0;
        end
        // Tenure ends only when the owner drops cyc.
        if (!cyc_g) begin
          state_d    = IDLE;
          last_idx_d = gnt_idx_q;
          grant_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      gnt_idx_q  <= '0;
      last_idx_q <= LAST_RST;
      wd_cnt_q   <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
      wd_cnt_q   <= wd_cnt_d;
      grant_q    <= grant_d;
    end
  end

endmodule
